// File: rtl/bin_image_stream_gen.sv
// ---------------------------------------------------------------------------
// bin_image_stream_gen
//   Replays a binary image held in an external 1-bit pixel memory as a
//   camera-style video stream (vsync / href / pixel). Frames are generated
//   back-to-back while enable is high; a frame in progress always completes.
//
// Ports
//   clk             pixel clock, all logic on its rising edge
//   rst_n           asynchronous active-low reset
//   enable          level; high = keep producing frames
//   rd_en           pixel-memory read strobe (registered)
//   rd_addr[19:0]   raster address of the pixel being read (registered)
//   rd_data         memory data, valid one clk after rd_en
//   per_frame_vsync frame sync, one clk behind the raster position
//   per_frame_href  active-pixel valid, aligned with rd_data
//   per_img_Bit     binary pixel, forced to 0 outside href
//   frame_done      1-clk pulse on the last clk of each frame
//   busy            high while a frame is in progress
// ---------------------------------------------------------------------------
module bin_image_stream_gen #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [10:0] H_BLANK   = 11'd160,
  parameter logic [10:0] V_SYNC    = 11'd2,
  parameter logic [10:0] V_BACK    = 11'd2,
  parameter logic [10:0] V_FRONT   = 11'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        rd_en,
  output logic [19:0] rd_addr,
  input  logic        rd_data,
  output logic        per_frame_vsync,
  output logic        per_frame_href,
  output logic        per_img_Bit,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [11:0] HDISP     = {1'b0, IMG_HDISP};
  localparam logic [11:0] VSYNC_END = {1'b0, V_SYNC};
  localparam logic [11:0] ACT_START = {1'b0, V_SYNC} + {1'b0, V_BACK};
  localparam logic [11:0] ACT_END   = ACT_START + {1'b0, IMG_VDISP};
  localparam logic [11:0] H_TOTAL   = {1'b0, IMG_HDISP} + {1'b0, H_BLANK};
  localparam logic [11:0] V_TOTAL   = ACT_END + {1'b0, V_FRONT};
  localparam logic [11:0] H_LAST    = H_TOTAL - 12'd1;
  localparam logic [11:0] V_LAST    = V_TOTAL - 12'd1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_reg;
  logic [11:0] h_cnt_reg, v_cnt_reg;
  logic [19:0] pix_cnt_reg;
  logic        rd_en_reg, vsync0_reg;
  logic        vsync_d_reg, href_d_reg;
  logic        frame_done_reg, busy_reg;

  // Raster position and run flag for the next clk. All stage-0 outputs are
  // decoded from these so they line up with the registered counters.
  logic        run_next;
  logic [11:0] h_next, v_next;

  always_comb begin
    run_next = 1'b0;
    h_next   = 12'd0;
    v_next   = 12'd0;
    case (state_reg)
      IDLE: run_next = enable;   // start presents (0,0) on the first RUN clk
      RUN: begin
        if (h_cnt_reg == H_LAST) begin
          if (v_cnt_reg == V_LAST) begin
            // End of frame: restart at (0,0) with no gap, or stop.
            run_next = enable;
          end else begin
            run_next = 1'b1;
            v_next   = v_cnt_reg + 12'd1;
          end
        end else begin
          run_next = 1'b1;
          h_next   = h_cnt_reg + 12'd1;
          v_next   = v_cnt_reg;
        end
      end
      default: run_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      h_cnt_reg      <= 12'd0;
      v_cnt_reg      <= 12'd0;
      pix_cnt_reg    <= 20'd0;
      rd_en_reg      <= 1'b0;
      vsync0_reg     <= 1'b0;
      vsync_d_reg    <= 1'b0;
      href_d_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= run_next ? RUN : IDLE;
      h_cnt_reg      <= h_next;
      v_cnt_reg      <= v_next;
      busy_reg       <= run_next;
      vsync0_reg     <= run_next && (v_next < VSYNC_END);
      rd_en_reg      <= run_next && (v_next >= ACT_START) && (v_next < ACT_END)
                        && (h_next < HDISP);
      frame_done_reg <= run_next && (h_next == H_LAST) && (v_next == V_LAST);
      // Pixel counter replaces line*HDISP+h: clear at every frame start,
      // step once after each read strobe.
      if (!run_next || (h_next == 12'd0 && v_next == 12'd0))
        pix_cnt_reg <= 20'd0;
      else if (rd_en_reg)
        pix_cnt_reg <= pix_cnt_reg + 20'd1;
      // One-clk delay matches the memory read latency.
      vsync_d_reg    <= vsync0_reg;
      href_d_reg     <= rd_en_reg;
    end
  end

  assign rd_en           = rd_en_reg;
  assign rd_addr         = pix_cnt_reg;
  assign per_frame_vsync = vsync_d_reg;
  assign per_frame_href  = href_d_reg;
  assign per_img_Bit     = href_d_reg & rd_data;
  assign frame_done      = frame_done_reg;
  assign busy            = busy_reg;

endmodule
